// File: rtl/spi_apb_bridge_fsm_if.sv
// SPI-shifter control and APB bus bundle for the bridge.
// master = the bridge itself; slave = the SPI shifter plus the APB targets.
interface spi_apb_bridge_fsm_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int TGT_W  = 1
);
  localparam int N_TGT = 2**TGT_W;

  // SPI shifter side
  logic                    cs_n;
  logic                    address_ready;
  logic                    data_ready;
  logic [ADDR_W-1:0]       addr;
  logic [TGT_W+1:0]        status;
  logic [DATA_W-1:0]       wdata;
  logic [DATA_W-1:0]       rdata;
  logic                    rdata_valid;
  logic                    err;
  logic                    busy;

  // APB side
  logic [N_TGT-1:0]        psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_W-1:0]       paddr;
  logic [DATA_W-1:0]       pwdata;
  logic [N_TGT-1:0]        pready;
  logic [N_TGT*DATA_W-1:0] prdata;
  logic [N_TGT-1:0]        pslverr;

  modport master (
    input  cs_n, address_ready, data_ready, addr, status, wdata,
    input  pready, prdata, pslverr,
    output psel, penable, pwrite, paddr, pwdata,
    output rdata, rdata_valid, err, busy
  );

  modport slave (
    output cs_n, address_ready, data_ready, addr, status, wdata,
    output pready, prdata, pslverr,
    input  psel, penable, pwrite, paddr, pwdata,
    input  rdata, rdata_valid, err, busy
  );
endinterface

// File: rtl/spi_apb_bridge_fsm.sv
// SPI-slave to APB-master control FSM: single or auto-incrementing burst transfers on one of 2**TGT_W targets.
// Latency: address_ready/data_ready -> psel +1 cycle, penable +2; pready sampled -> rdata_valid +1.
// Backpressure: stalls in ACCESS on pready (bounded by TIMEOUT) and between beats on data_ready from the shifter.
module spi_apb_bridge_fsm #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int TGT_W     = 1,
  parameter int ADDR_STEP = 1,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_apb_bridge_fsm_if.master bus
);
  localparam int N_TGT  = 2**TGT_W;
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int TMO_W  = $clog2(TIMEOUT);

  typedef struct packed {
    logic             write;
    logic             burst;
    logic [TGT_W-1:0] tgt;
  } status_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WD,
    SETUP,
    ACCESS,
    WAIT_RD,
    DONE
  } state_t;

  state_t             state_q, state_d;
  status_t            stat_q, stat_d;
  logic [N_TGT-1:0]   psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               err_q, err_d;
  logic [BEAT_W-1:0]  beats_q, beats_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               abort_q, abort_d;

  status_t            st_in;
  logic               bad_status;
  logic [N_TGT-1:0]   sel_new;
  logic [N_TGT-1:0]   sel_cur;
  logic               tgt_ready;
  logic               tgt_slverr;
  logic [DATA_W-1:0]  tgt_rdata;
  logic               beat_limit;

  assign st_in      = status_t'(bus.status);
  // Target decode is dense for a power-of-two N_TGT, so only X status can trap there.
  assign bad_status = $isunknown(bus.status) || (int'(st_in.tgt) >= N_TGT);
  assign sel_new    = N_TGT'(1) << st_in.tgt;
  assign sel_cur    = N_TGT'(1) << stat_q.tgt;
  assign tgt_ready  = bus.pready[stat_q.tgt];
  assign tgt_slverr = bus.pslverr[stat_q.tgt];
  assign tgt_rdata  = bus.prdata[stat_q.tgt*DATA_W +: DATA_W];
  assign beat_limit = (beats_q == BEAT_W'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      stat_q        <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      beats_q       <= '0;
      tmo_q         <= '0;
      abort_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      stat_q        <= stat_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
      beats_q       <= beats_d;
      tmo_q         <= tmo_d;
      abort_q       <= abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stat_d        = stat_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = err_q;
    beats_d       = beats_q;
    tmo_d         = tmo_q;
    abort_d       = abort_q;

    unique case (state_q)
      IDLE: begin
        if (bus.address_ready) begin
          stat_d   = st_in;
          paddr_d  = bus.addr;
          pwrite_d = st_in.write;
          err_d    = 1'b0;
          beats_d  = '0;
          abort_d  = 1'b0;
          if (bad_status) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (st_in.write) begin
            state_d = WAIT_WD;
          end else begin
            psel_d  = sel_new;
            state_d = SETUP;
          end
        end
      end

      WAIT_WD: begin
        if (bus.cs_n) begin
          state_d = IDLE;
        end else if (bus.data_ready) begin
          if (beat_limit) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            pwdata_d = bus.wdata;
            psel_d   = sel_cur;
            state_d  = SETUP;
          end
        end
      end

      SETUP: begin
        // Frame ended before the enable phase: back out without running the transfer.
        if (bus.cs_n) begin
          psel_d  = '0;
          state_d = IDLE;
        end else begin
          penable_d = 1'b1;
          tmo_d     = '0;
          abort_d   = 1'b0;
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        if (bus.cs_n) begin
          abort_d = 1'b1;
        end
        if (tgt_ready) begin
          psel_d    = '0;
          penable_d = 1'b0;
          beats_d   = beats_q + BEAT_W'(1);
          if (tgt_slverr) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            if (!stat_q.write) begin
              rdata_d       = tgt_rdata;
              rdata_valid_d = 1'b1;
            end
            if (!stat_q.burst) begin
              state_d = DONE;
            end else begin
              paddr_d = paddr_q + ADDR_W'(ADDR_STEP);
              state_d = stat_q.write ? WAIT_WD : WAIT_RD;
            end
          end
          // A frame that ended mid-transfer returns straight to IDLE once the beat completes.
          if (abort_q || bus.cs_n) begin
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          err_d     = 1'b1;
          state_d   = (abort_q || bus.cs_n) ? IDLE : DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      WAIT_RD: begin
        if (bus.cs_n) begin
          state_d = IDLE;
        end else if (bus.data_ready) begin
          if (beat_limit) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            psel_d  = sel_cur;
            state_d = SETUP;
          end
        end
      end

      DONE: begin
        if (bus.cs_n) begin
          state_d = IDLE;
        end
      end

      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_spi_apb_bridge_fsm.sv
// Scoreboard bench for spi_apb_bridge_fsm: expected APB beats and read words are queued at stimulus time
// and checked by a negedge monitor; each scenario task also checks state/err/latency inline.
module tb_spi_apb_bridge_fsm;
  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int TGT_W     = 1;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 8;

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [19:0] addr;
    logic [15:0] wdat;
  } apb_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   setup_cnt;

  apb_t        apb_q[$];
  logic [15:0] rd_q[$];
  apb_t        mon_exp;
  logic [15:0] mon_rd;

  logic [1:0]  pready_en;
  logic [1:0]  slverr;
  logic [15:0] rd0;
  logic [15:0] rd1;

  spi_apb_bridge_fsm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TGT_W(TGT_W)) bus ();

  spi_apb_bridge_fsm #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TGT_W(TGT_W),
    .ADDR_STEP(1), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.pready  = pready_en;
  assign bus.pslverr = slverr;
  assign bus.prdata  = {rd1, rd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: APB completions and read words, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.psel != 2'b00 && !bus.penable) setup_cnt++;
    if (!reset && bus.psel != 2'b00 && bus.penable && (bus.psel & bus.pready) != 2'b00) begin
      tests++;
      if (apb_q.size() == 0) begin
        fails++;
        $display("FAIL apb_unexpected: got sel=%b addr=%h wr=%b, no transfer expected", bus.psel, bus.paddr, bus.pwrite);
      end else begin
        mon_exp = apb_q.pop_front();
        if (bus.psel !== mon_exp.sel || bus.paddr !== mon_exp.addr || bus.pwrite !== mon_exp.wr ||
            (mon_exp.wr && bus.pwdata !== mon_exp.wdat)) begin
          fails++;
          $display("FAIL apb_xfer: got sel=%b addr=%h wr=%b wd=%h, want sel=%b addr=%h wr=%b wd=%h",
                   bus.psel, bus.paddr, bus.pwrite, bus.pwdata, mon_exp.sel, mon_exp.addr, mon_exp.wr, mon_exp.wdat);
        end
      end
    end
    if (!reset && bus.rdata_valid) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL rdata_unexpected: got %h, no read word expected", bus.rdata);
      end else begin
        mon_rd = rd_q.pop_front();
        if (bus.rdata !== mon_rd) begin
          fails++;
          $display("FAIL rdata: got %h, want %h", bus.rdata, mon_rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_addr(input logic [19:0] a, input logic [2:0] st);
    bus.addr          = a;
    bus.status        = st;
    bus.address_ready = 1'b1;
    tick();
    bus.address_ready = 1'b0;
  endtask

  task automatic pulse_data(input logic [15:0] w);
    bus.wdata      = w;
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (apb_q.size() == 0 && rd_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic end_frame();
    bus.cs_n = 1'b1;
    tick();
    bus.cs_n = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if (bus.psel !== 2'b00 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got psel=%b penable=%b pwrite=%b, want 00/0/0", bus.psel, bus.penable, bus.pwrite);
    end
    tests++;
    if (bus.paddr !== 20'h0 || bus.pwdata !== 16'h0 || bus.rdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h, want 0", bus.paddr, bus.pwdata, bus.rdata);
    end
    tests++;
    if (bus.rdata_valid !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: got rv=%b err=%b busy=%b, want 0/0/0", bus.rdata_valid, bus.err, bus.busy);
    end
  endtask

  task automatic test_read_latency();
    bit ok;
    rd0 = 16'h1357;
    apb_q.push_back('{1'b0, 2'b01, 20'h00010, 16'h0});
    rd_q.push_back(16'h1357);
    bus.addr = 20'h00010; bus.status = 3'b000; bus.address_ready = 1'b1;
    tick();
    bus.address_ready = 1'b0;
    tests++;
    if (bus.psel !== 2'b01 || bus.penable !== 1'b0) begin
      fails++;
      $display("FAIL rd_lat_setup: got psel=%b penable=%b, want 01/0", bus.psel, bus.penable);
    end
    tick();
    tests++;
    if (bus.penable !== 1'b1) begin
      fails++;
      $display("FAIL rd_lat_access: got penable=%b, want 1", bus.penable);
    end
    tick();
    tests++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== 16'h1357) begin
      fails++;
      $display("FAIL rd_lat_rdv: got rv=%b rdata=%h, want 1/1357", bus.rdata_valid, bus.rdata);
    end
    drain(20, ok);
    end_frame();
  endtask

  task automatic test_write_single();
    bit ok;
    pulse_addr(20'h00208, 3'b100);
    apb_q.push_back('{1'b1, 2'b01, 20'h00208, 16'h1234});
    pulse_data(16'h1234);
    tests++;
    if (bus.psel !== 2'b01 || bus.penable !== 1'b0) begin
      fails++;
      $display("FAIL wr_lat_setup: got psel=%b penable=%b, want 01/0", bus.psel, bus.penable);
    end
    drain(20, ok);
    tick();
    tests++;
    if (!ok || bus.busy !== 1'b1 || bus.psel !== 2'b00 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL wr_single_done: got drained=%0d busy=%b psel=%b err=%b, want 1/1/00/0", ok, bus.busy, bus.psel, bus.err);
    end
    end_frame();
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL wr_single_idle: got busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_burst_write();
    bit ok;
    bit all_ok;
    logic [15:0] words[3];
    words = '{16'h1234, 16'h1235, 16'h1236};
    all_ok = 1'b1;
    slverr = 2'b10;
    pulse_addr(20'h01122, 3'b110);
    for (int i = 0; i < 3; i++) begin
      apb_q.push_back('{1'b1, 2'b01, 20'h01122 + 20'(i), words[i]});
      pulse_data(words[i]);
      drain(20, ok);
      all_ok &= ok;
    end
    end_frame();
    slverr = 2'b00;
    tests++;
    if (!all_ok || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL burst_write: got drained=%0d busy=%b err=%b, want 1/0/0", all_ok, bus.busy, bus.err);
    end
  endtask

  task automatic test_burst_read_wrap();
    bit ok1;
    bit ok2;
    rd1 = 16'hF0F1;
    apb_q.push_back('{1'b0, 2'b10, 20'hFFFFF, 16'h0});
    rd_q.push_back(16'hF0F1);
    pulse_addr(20'hFFFFF, 3'b011);
    drain(20, ok1);
    rd1 = 16'hABC1;
    apb_q.push_back('{1'b0, 2'b10, 20'h00000, 16'h0});
    rd_q.push_back(16'hABC1);
    pulse_data(16'h0);
    drain(20, ok2);
    end_frame();
    tests++;
    if (!ok1 || !ok2 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL burst_read: got drained=%0d%0d err=%b busy=%b, want 11/0/0", ok1, ok2, bus.err, bus.busy);
    end
  endtask

  task automatic test_slverr();
    bit ok;
    int sc;
    slverr = 2'b10;
    pulse_addr(20'h0BAAB, 3'b101);
    apb_q.push_back('{1'b1, 2'b10, 20'h0BAAB, 16'h00EE});
    pulse_data(16'h00EE);
    drain(20, ok);
    tick();
    tests++;
    if (!ok || bus.err !== 1'b1 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL slverr_err: got drained=%0d err=%b busy=%b, want 1/1/1", ok, bus.err, bus.busy);
    end
    sc = setup_cnt;
    pulse_data(16'h9999);
    repeat (3) tick();
    tests++;
    if (setup_cnt !== sc || bus.psel !== 2'b00) begin
      fails++;
      $display("FAIL slverr_no_apb: got setups=%0d psel=%b, want %0d/00", setup_cnt, bus.psel, sc);
    end
    end_frame();
    slverr = 2'b00;
    tests++;
    if (bus.err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got err=%b, want 1", bus.err);
    end
    rd0 = 16'h2468;
    apb_q.push_back('{1'b0, 2'b01, 20'h00010, 16'h0});
    rd_q.push_back(16'h2468);
    pulse_addr(20'h00010, 3'b000);
    tests++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got err=%b, want 0", bus.err);
    end
    drain(20, ok);
    end_frame();
  endtask

  task automatic test_timeout();
    int pen_cnt;
    pen_cnt = 0;
    pready_en = 2'b00;
    pulse_addr(20'h00300, 3'b000);
    for (int i = 0; i < 4 * TIMEOUT; i++) begin
      tick();
      if (bus.penable === 1'b1) pen_cnt++;
      if (bus.err === 1'b1) break;
    end
    tests++;
    if (pen_cnt != TIMEOUT || bus.err !== 1'b1 || bus.psel !== 2'b00 || bus.penable !== 1'b0) begin
      fails++;
      $display("FAIL timeout: got access_cycles=%0d err=%b psel=%b penable=%b, want %0d/1/00/0",
               pen_cnt, bus.err, bus.psel, bus.penable, TIMEOUT);
    end
    end_frame();
    pready_en = 2'b11;
  endtask

  task automatic test_reset_mid_access();
    pready_en = 2'b00;
    pulse_addr(20'h00400, 3'b001);
    for (int i = 0; i < 10 && bus.penable !== 1'b1; i++) tick();
    tests++;
    if (bus.penable !== 1'b1 || bus.psel !== 2'b10) begin
      fails++;
      $display("FAIL rst_mid_reach: got psel=%b penable=%b, want 10/1", bus.psel, bus.penable);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (bus.psel !== 2'b00 || bus.penable !== 1'b0 || bus.busy !== 1'b0 || bus.paddr !== 20'h0 || bus.rdata !== 16'h0) begin
      fails++;
      $display("FAIL rst_mid: got psel=%b penable=%b busy=%b paddr=%h rdata=%h, want 00/0/0/0/0",
               bus.psel, bus.penable, bus.busy, bus.paddr, bus.rdata);
    end
    reset = 1'b0;
    pready_en = 2'b11;
    tick();
  endtask

  task automatic test_burst_overflow();
    bit ok;
    bit all_ok;
    int sc;
    all_ok = 1'b1;
    pulse_addr(20'h00500, 3'b110);
    for (int i = 0; i < MAX_BURST; i++) begin
      apb_q.push_back('{1'b1, 2'b01, 20'h00500 + 20'(i), 16'hA000 + 16'(i)});
      pulse_data(16'hA000 + 16'(i));
      drain(20, ok);
      all_ok &= ok;
    end
    tick();
    tests++;
    if (!all_ok || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL overflow_beats: got drained=%0d err=%b, want 1/0", all_ok, bus.err);
    end
    sc = setup_cnt;
    pulse_data(16'hBEEF);
    repeat (3) tick();
    tests++;
    if (bus.err !== 1'b1 || setup_cnt !== sc) begin
      fails++;
      $display("FAIL overflow_err: got err=%b setups=%0d, want 1/%0d", bus.err, setup_cnt, sc);
    end
    end_frame();
  endtask

  task automatic test_cs_mid_access();
    bit ok;
    pready_en = 2'b00;
    pulse_addr(20'h00600, 3'b111);
    apb_q.push_back('{1'b1, 2'b10, 20'h00600, 16'h5555});
    pulse_data(16'h5555);
    for (int i = 0; i < 10 && bus.penable !== 1'b1; i++) tick();
    bus.cs_n = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.penable !== 1'b1 || bus.psel !== 2'b10) begin
      fails++;
      $display("FAIL cs_hold_access: got psel=%b penable=%b, want 10/1", bus.psel, bus.penable);
    end
    pready_en = 2'b11;
    drain(20, ok);
    tick();
    tests++;
    if (!ok || bus.busy !== 1'b0 || bus.psel !== 2'b00) begin
      fails++;
      $display("FAIL cs_finish_idle: got drained=%0d busy=%b psel=%b, want 1/0/00", ok, bus.busy, bus.psel);
    end
    bus.cs_n = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    setup_cnt = 0;
    reset = 1'b1;
    pready_en = 2'b11;
    slverr = 2'b00;
    rd0 = 16'h0;
    rd1 = 16'h0;
    bus.cs_n = 1'b1;
    bus.address_ready = 1'b0;
    bus.data_ready = 1'b0;
    bus.addr = '0;
    bus.status = '0;
    bus.wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    test_reset();
    bus.cs_n = 1'b0;
    test_read_latency();
    test_write_single();
    test_burst_write();
    test_burst_read_wrap();
    test_slverr();
    test_timeout();
    test_reset_mid_access();
    test_burst_overflow();
    test_cs_mid_access();
    tests++;
    if (apb_q.size() != 0 || rd_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: got %0d apb and %0d read entries pending, want 0/0", apb_q.size(), rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
